// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = (digit_i >= BCD_ADD3_THRESH) ? digit_i + 4'd3 : digit_i;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per cycle.
// Define BIN2BCD_SIGNED_EN for two's-complement input and the neg output.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    valor,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [DIGITS*4-1:0] bcd
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                neg
`endif
);

    localparam int unsigned BcdW = DIGITS * 4;
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic [BcdW-1:0]      scratch_q, scratch_d;
    logic [BcdW-1:0]      bcd_q, bcd_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BcdW-1:0]      adj;
    logic [BcdW+WIDTH-1:0] pair_sh;
    logic [WIDTH-1:0]     mag;

`ifdef BIN2BCD_SIGNED_EN
    logic sign_q, sign_d;
    logic neg_q, neg_d;

    // Negating the most negative value wraps to 2^(WIDTH-1), which is the wanted magnitude.
    always_comb begin
        mag = valor[WIDTH-1] ? -valor : valor;
    end
`else
    always_comb begin
        mag = valor;
    end
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : gen_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[g*4 +: 4]),
            .digit_o (adj[g*4 +: 4])
        );
    end

    always_comb begin
        pair_sh = {adj, bin_q} << 1;
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
`ifdef BIN2BCD_SIGNED_EN
        sign_d    = sign_q;
        neg_d     = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SHIFT;
                    bin_d     = mag;
                    scratch_d = '0;
                    cnt_d     = '0;
`ifdef BIN2BCD_SIGNED_EN
                    sign_d    = valor[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                bin_d     = pair_sh[WIDTH-1:0];
                scratch_d = pair_sh[BcdW+WIDTH-1:WIDTH];
                cnt_d     = cnt_q + CntW'(1);
                // The last shift's result goes straight to the output register.
                if (cnt_q == LastCnt) begin
                    state_d = DONE;
                    bcd_d   = pair_sh[BcdW+WIDTH-1:WIDTH];
`ifdef BIN2BCD_SIGNED_EN
                    neg_d   = sign_q;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
`ifdef BIN2BCD_SIGNED_EN
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
`ifdef BIN2BCD_SIGNED_EN
            sign_q    <= sign_d;
            neg_q     <= neg_d;
`endif
        end
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        bcd  = bcd_q;
`ifdef BIN2BCD_SIGNED_EN
        neg  = neg_q;
`endif
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus queues expected results, a monitor checks on done.
module tb_bin2bcd_seq;

    localparam int unsigned W = 9;
    localparam int unsigned D = 3;

    typedef struct packed {
        logic [11:0] bcd;
        logic        neg;
    } exp_t;

`ifdef BIN2BCD_SIGNED_EN
    localparam logic [8:0]  VEC_V [6] = '{9'h000, 9'h0FF, 9'h1FF, 9'h100, 9'h001, 9'h19C};
    localparam logic [11:0] VEC_B [6] = '{12'h000, 12'h255, 12'h001, 12'h256, 12'h001, 12'h100};
    localparam logic        VEC_N [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    localparam logic [8:0]  VEC_V [6] = '{9'd0, 9'd255, 9'd511, 9'd256, 9'd1, 9'd100};
    localparam logic [11:0] VEC_B [6] = '{12'h000, 12'h255, 12'h511, 12'h256, 12'h001, 12'h100};
    localparam logic        VEC_N [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   valor;
    logic           busy;
    logic           done;
    logic [D*4-1:0] bcd;
`ifdef BIN2BCD_SIGNED_EN
    logic           neg;
`endif

    bin2bcd_seq #(
        .WIDTH  (W),
        .DIGITS (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .valor (valor),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef BIN2BCD_SIGNED_EN
        ,
        .neg   (neg)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   done_cnt = 0;
    int   stream_base = 0;
    bit   gap_chk = 1'b0;
    int unsigned last_done = 0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("bcd", 32'(bcd), 32'(mon_e.bcd));
`ifdef BIN2BCD_SIGNED_EN
                check("neg", 32'(neg), 32'(mon_e.neg));
`endif
            end
            if (gap_chk && done_cnt > stream_base) begin
                check("done_period", cyc - last_done, 32'd11);
            end
            last_done = cyc;
            done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [8:0] v, input logic [11:0] eb, input logic en,
                           input bit timing, input logic [11:0] prev);
        valor = v;
        start = 1'b1;
        exp_q.push_back('{bcd: eb, neg: en});
        tick();
        start = 1'b0;
        valor = 9'($urandom);
        if (timing) begin
            for (int i = 0; i < W; i++) begin
                check("busy_shift", 32'(busy), 32'd1);
                check("done_low_shift", 32'(done), 32'd0);
                check("bcd_hold", 32'(bcd), 32'(prev));
                tick();
            end
            check("done_pulse", 32'(done), 32'd1);
            check("busy_in_done", 32'(busy), 32'd0);
            tick();
            check("done_one_cycle", 32'(done), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
        end else begin
            repeat (W + 2) tick();
        end
    endtask

    logic [11:0] prev;
    int          d0;

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        valor = 9'd5;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
`ifdef BIN2BCD_SIGNED_EN
        check("rst_neg", 32'(neg), 32'd0);
`endif
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check("start_in_reset_ignored", 32'(busy), 32'd0);

        convert(9'd0, 12'h000, 1'b0, 1'b1, 12'h000);
        prev = 12'h000;
        for (int i = 0; i < 6; i++) begin
            convert(VEC_V[i], VEC_B[i], VEC_N[i], (i == 2), prev);
            prev = VEC_B[i];
        end

        // Second request during SHIFT and DONE must be dropped.
        d0 = done_cnt;
        valor = 9'd123;
        start = 1'b1;
        exp_q.push_back('{bcd: 12'h123, neg: 1'b0});
        tick();
        valor = 9'd77;
        repeat (W + 1) tick();
        start = 1'b0;
        repeat (15) tick();
        check("dropped_request", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of a conversion aborts it.
        d0 = done_cnt;
        valor = 9'd99;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
`ifdef BIN2BCD_SIGNED_EN
        check("abort_neg", 32'(neg), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        convert(9'd99, 12'h099, 1'b0, 1'b0, 12'h000);

        // Start held high: a new conversion on every return to IDLE.
        stream_base = done_cnt;
        gap_chk = 1'b1;
        repeat (4) exp_q.push_back('{bcd: 12'h042, neg: 1'b0});
        valor = 9'd42;
        start = 1'b1;
        repeat (40) tick();
        start = 1'b0;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        gap_chk = 1'b0;
        check("stream_count", 32'(done_cnt - stream_base), 32'd4);

        repeat (15) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
